// File: rtl/ks_string_voice_if.sv
// Control/audio bundle between the note controller, the sample-rate divider and one string voice.
// master = controller/divider side, slave = the voice.
interface ks_string_voice_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              pluck;
  logic              mute;
  logic [ADDR_W-1:0] len;
  logic              sample_en;
  logic [WIDTH-1:0]  sample;
  logic              valid;
  logic              busy;

  modport master (
    output pluck, mute, len, sample_en,
    input  sample, valid, busy
  );

  modport slave (
    input  pluck, mute, len, sample_en,
    output sample, valid, busy
  );
endinterface

// File: rtl/ks_string_voice.sv
// Karplus-Strong string voice: LFSR-noise-loaded circular delay line recirculated through a
// two-tap averaging low-pass once per sample_en. Define KS_DECAY_EN for extra DECAY_SHIFT attenuation.
module ks_string_voice #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DECAY_SHIFT = 4
) (
  input  logic             clok,
  input  logic             rst_n,
  ks_string_voice_if.slave voice
);

  localparam int unsigned MAX_LEN = 1 << ADDR_W;
  localparam int unsigned LFSR_W  = 16;

`ifdef KS_DECAY_EN
  localparam bit DECAY_ON = 1'b1;
`else
  localparam bit DECAY_ON = 1'b0;
`endif
  // Shifting a WIDTH-bit value by WIDTH yields zero, so the plain build reduces to y = avg.
  localparam int unsigned DSH = DECAY_ON ? DECAY_SHIFT : WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   len_q;
  logic [LFSR_W-1:0]   lfsr;
  logic [WIDTH-1:0]    sample_q;
  logic                valid_q;
  logic                busy_q;

  logic [WIDTH-1:0]    dline [MAX_LEN];

  logic                fb_c;
  logic                accept_c;
  logic [ADDR_W-1:0]   len_clamp_c;
  logic [ADDR_W-1:0]   last_c;
  logic [ADDR_W-1:0]   nxt_c;
  logic [WIDTH:0]      sum_c;
  logic [WIDTH-1:0]    avg_c;
  logic [WIDTH-1:0]    y_c;
  logic                we_c;
  logic [WIDTH-1:0]    wdata_c;

  // Filter datapath and control decode.
  always_comb begin
    fb_c        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    accept_c    = voice.pluck && !voice.mute && (state != S_LOAD);
    len_clamp_c = (voice.len < ADDR_W'(2)) ? ADDR_W'(2) : voice.len;
    last_c      = len_q - ADDR_W'(1);
    nxt_c       = (ptr == last_c) ? '0 : ptr + ADDR_W'(1);
    sum_c       = {1'b0, dline[ptr]} + {1'b0, dline[nxt_c]};
    avg_c       = sum_c[WIDTH:1];
    y_c         = avg_c - (avg_c >> DSH);
    we_c        = 1'b0;
    wdata_c     = y_c;
    if (rst_n && !voice.mute) begin
      if (state == S_LOAD) begin
        we_c    = 1'b1;
        wdata_c = WIDTH'(lfsr);
      end else if (state == S_PLAY && voice.sample_en && !accept_c) begin
        we_c    = 1'b1;
      end
    end
  end

  // Delay line: never reset, written at ptr during LOAD and on each PLAY strobe.
  always_ff @(posedge clok) begin
    if (we_c) begin
      dline[ptr] <= wdata_c;
    end
  end

  // Control FSM with registered outputs; mute outranks pluck, pluck outranks sample_en.
  always_ff @(posedge clok) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      len_q    <= ADDR_W'(2);
      lfsr     <= 16'hACE1;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (voice.mute) begin
        state    <= S_IDLE;
        sample_q <= '0;
        busy_q   <= 1'b0;
      end else if (accept_c) begin
        len_q  <= len_clamp_c;
        ptr    <= '0;
        state  <= S_LOAD;
        busy_q <= 1'b1;
      end else begin
        case (state)
          S_LOAD: begin
            lfsr <= {lfsr[14:0], fb_c};
            if (ptr == last_c) begin
              ptr    <= '0;
              state  <= S_PLAY;
              busy_q <= 1'b0;
            end else begin
              ptr <= ptr + ADDR_W'(1);
            end
          end
          S_PLAY: begin
            if (voice.sample_en) begin
              sample_q <= y_c;
              valid_q  <= 1'b1;
              ptr      <= nxt_c;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign voice.sample = sample_q;
  assign voice.valid  = valid_q;
  assign voice.busy   = busy_q;

endmodule

// File: tb/tb_ks_string_voice.sv
// Bench for ks_string_voice: directed stimulus, expected samples queued at strobe time and
// checked by an independent monitor whenever valid is seen.
module tb_ks_string_voice;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = 8;

`ifdef KS_DECAY_EN
  localparam logic [7:0] H1 = 8'hC5;
  localparam logic [7:0] H2 = 8'hB8;
`else
  localparam logic [7:0] H1 = 8'hD2;
  localparam logic [7:0] H2 = 8'hCA;
`endif

  logic clok  = 1'b0;
  logic rst_n = 1'b0;

  ks_string_voice_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) vif ();

  ks_string_voice #(
    .WIDTH(WIDTH),
    .ADDR_W(ADDR_W),
    .DECAY_SHIFT(4)
  ) dut (
    .clok (clok),
    .rst_n(rst_n),
    .voice(vif)
  );

  always #5 clok = ~clok;

  int total  = 0;
  int bad    = 0;
  int scount = 0;
  int vcount = 0;

  logic [7:0]  mdl [256];
  int          mptr  = 0;
  int          mlen  = 2;
  logic [15:0] mlfsr = 16'hACE1;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [7:0] model_y(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] avg;
    s   = {1'b0, a} + {1'b0, b};
    avg = s[8:1];
`ifdef KS_DECAY_EN
    return avg - (avg >> 4);
`else
    return avg;
`endif
  endfunction

  // Monitor: every valid must match the oldest queued expectation.
  always @(negedge clok) begin
    if (vif.valid) begin
      vcount++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("sample", int'(vif.sample), int'(mon_exp));
      end
    end
  end

  // Pluck pulse (optionally with a coincident sample_en), then measure the busy window.
  task automatic pluck_load(input int l, input bit with_se);
    int n;
    @(negedge clok);
    vif.pluck     = 1'b1;
    vif.len       = ADDR_W'(l);
    vif.sample_en = with_se;
    @(negedge clok);
    vif.pluck     = 1'b0;
    vif.sample_en = 1'b0;
    vif.len       = 8'd7;
    if (with_se) chk("pluck_beats_strobe_valid", int'(vif.valid), 0);
    mlen = (l < 2) ? 2 : l;
    mptr = 0;
    for (int i = 0; i < mlen; i++) begin
      mdl[i] = mlfsr[7:0];
      mlfsr  = lfsr_step(mlfsr);
    end
    n = 0;
    while (vif.busy && n < 600) begin
      n++;
      @(negedge clok);
    end
    chk("busy_cycles", n, mlen);
  endtask

  task automatic strobe();
    int nx;
    logic [7:0] y;
    @(negedge clok);
    vif.sample_en = 1'b1;
    nx = (mptr == mlen - 1) ? 0 : mptr + 1;
    y = model_y(mdl[mptr], mdl[nx]);
    mdl[mptr] = y;
    mptr = nx;
    exp_q.push_back(y);
    scount++;
    @(negedge clok);
    vif.sample_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] maxv;
    int f_min, f_max, l_min, l_max;
    vif.pluck     = 1'b0;
    vif.mute      = 1'b0;
    vif.len       = '0;
    vif.sample_en = 1'b0;

    // Reset and idle strobes.
    repeat (2) @(negedge clok);
    chk("rst_sample", int'(vif.sample), 0);
    chk("rst_valid", int'(vif.valid), 0);
    chk("rst_busy", int'(vif.busy), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clok);
      vif.sample_en = 1'b1;
      @(negedge clok);
      vif.sample_en = 1'b0;
      chk("idle_valid", int'(vif.valid), 0);
    end

    // len=2 with hand-computed noise and first outputs.
    pluck_load(2, 1'b0);
    chk("dline0", int'(dut.dline[0]), 'hE1);
    chk("dline1", int'(dut.dline[1]), 'hC3);
    strobe();
    chk("first_sample", int'(vif.sample), int'(H1));
    chk("first_valid", int'(vif.valid), 1);
    @(negedge clok);
    chk("valid_one_cycle", int'(vif.valid), 0);
    strobe();
    chk("second_sample", int'(vif.sample), int'(H2));

    // Length clamp and wrap.
    pluck_load(0, 1'b0);
    repeat (3) strobe();
    pluck_load(5, 1'b0);
    maxv = 8'd0;
    for (int i = 0; i < 5; i++) if (mdl[i] > maxv) maxv = mdl[i];
    for (int i = 0; i < 12; i++) begin
      strobe();
      chk("bounded_by_max", int'(vif.sample > maxv), 0);
    end

    // pluck beats sample_en in PLAY.
    pluck_load(3, 1'b1);
    repeat (4) strobe();

    // pluck with mute: mute wins.
    @(negedge clok);
    vif.pluck = 1'b1;
    vif.mute  = 1'b1;
    vif.len   = 8'd4;
    @(negedge clok);
    vif.pluck = 1'b0;
    vif.mute  = 1'b0;
    chk("pm_busy", int'(vif.busy), 0);
    chk("pm_sample", int'(vif.sample), 0);
    vif.sample_en = 1'b1;
    @(negedge clok);
    vif.sample_en = 1'b0;
    chk("pm_no_valid", int'(vif.valid), 0);

    // mute two entries into LOAD.
    @(negedge clok);
    vif.pluck = 1'b1;
    vif.len   = 8'd5;
    @(negedge clok);
    vif.pluck = 1'b0;
    @(negedge clok);
    @(negedge clok);
    chk("load_busy", int'(vif.busy), 1);
    vif.mute = 1'b1;
    @(negedge clok);
    vif.mute = 1'b0;
    chk("mute_load_busy", int'(vif.busy), 0);
    chk("mute_load_sample", int'(vif.sample), 0);
    mlfsr = lfsr_step(lfsr_step(mlfsr));

    // Reset mid-PLAY reseeds the LFSR.
    pluck_load(3, 1'b0);
    repeat (2) strobe();
    @(negedge clok);
    rst_n = 1'b0;
    @(negedge clok);
    chk("midrst_sample", int'(vif.sample), 0);
    chk("midrst_busy", int'(vif.busy), 0);
    rst_n = 1'b1;
    mlfsr = 16'hACE1;
    pluck_load(2, 1'b0);
    strobe();
    chk("reseed_first_sample", int'(vif.sample), int'(H1));

    // Long run: outputs settle.
    pluck_load(100, 1'b0);
    f_min = 255; f_max = 0; l_min = 255; l_max = 0;
    for (int i = 0; i < 10000; i++) begin
      strobe();
      if (i < 100) begin
        if (int'(vif.sample) < f_min) f_min = int'(vif.sample);
        if (int'(vif.sample) > f_max) f_max = int'(vif.sample);
      end else if (i >= 9900) begin
        if (int'(vif.sample) < l_min) l_min = int'(vif.sample);
        if (int'(vif.sample) > l_max) l_max = int'(vif.sample);
      end
    end
    chk("spread_shrinks", int'((l_max - l_min) < (f_max - f_min)), 1);

    repeat (3) @(negedge clok);
    chk("valid_count", vcount, scount);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ks_string_voice.md
# ks_string_voice

Parametrised Karplus-Strong string voice: a programmable-length circular delay line, pre-loaded with LFSR noise on a pluck and recirculated through a two-tap averaging low-pass filter once per sample strobe. It generalises the fixed 8-bit averaging filter into a complete voice, with configurable sample width and delay depth, a pluck/mute control state machine and optional extra decay. It sits between the note/pitch controller (pluck, len, mute) and the audio output path, with sample_en supplied by the sample-rate divider.

## Interface
- WIDTH, 8: sample width in bits, unsigned.
- ADDR_W, 8: delay-line address width; depth MAX_LEN = 2**ADDR_W entries.
- DECAY_SHIFT, 4: attenuation shift; used only with KS_DECAY_EN.

- clok  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- pluck  in  1  start a note; one-cycle pulse.
- mute  in  1  stop the note, return to IDLE.
- len  in  ADDR_W  delay length (pitch period) in samples; sampled on accepted pluck.
- sample_en  in  1  sample-rate strobe; one clok wide.
- sample  out  WIDTH  current output sample, registered.
- valid  out  1  one-cycle pulse when sample updates in PLAY.
- busy  out  1  high while in LOAD.

## Operation
- States: IDLE, LOAD, PLAY. Reset → IDLE; ptr=0, len_q=2, lfsr=16'hACE1, sample=0, valid=0, busy=0.
- Accepted pluck (in IDLE or PLAY, mute low): len_q <= max(len,2); ptr <= 0; → LOAD. In PLAY this restarts the note.
- LOAD: each clok, buf[ptr] <= lfsr[WIDTH-1:0], lfsr advances, ptr++. After buf[len_q-1] is written, ptr <= 0 and → PLAY. pluck and sample_en are ignored in LOAD.
- LFSR: 16-bit Fibonacci, fb = l[15]^l[13]^l[12]^l[10], l <= {l[14:0],fb}. It advances only in LOAD and is not reseeded by pluck.
- PLAY, on sample_en: nxt = (ptr==len_q-1) ? 0 : ptr+1.
  - avg = (buf[ptr] + buf[nxt]) >> 1, with the sum computed at WIDTH+1 bits.
  - y = avg, or the decay form under KS_DECAY_EN.
  - buf[ptr] <= y; sample <= y; valid <= 1; ptr <= nxt.
- mute: highest priority after reset, in any state. → IDLE, sample <= 0, busy <= 0. Delay-line contents are left unchanged.
- Simultaneous pluck and sample_en in PLAY: pluck wins and no sample is produced.
- Simultaneous pluck and mute: mute wins.
- Delay-line contents are not reset. IDLE and LOAD never read them.

## Timing
- Pluck accepted at edge N: busy is high from N+1 through the edge that writes the last entry. LOAD lasts len_q clocks, then the voice enters PLAY.
- sample_en high at edge M in PLAY: sample and valid update at edge M (visible after M). Latency is one clok. valid is low at all other times.
- Output rate equals the sample_en rate. Pitch = f_sample_en / (len_q + 0.5).
- len changes after pluck have no effect until the next pluck.
- Reset mid-LOAD or mid-PLAY: outputs and state return to reset values on that edge, and the LFSR is reseeded to 16'hACE1.

## Configuration
- KS_DECAY_EN defined: y = avg - (avg >> DECAY_SHIFT), giving faster decay and a shorter sustain.
- KS_DECAY_EN undefined: y = avg, the pure averaging filter. DECAY_SHIFT is unused.

## Test plan
- Reset: hold rst_n=0 for 2 clocks → sample=0, valid=0, busy=0. With sample_en toggling in IDLE, valid stays 0.
- Pluck, len=2, defaults, no macro:
  - busy high for exactly 2 clocks; buf = {8'hE1, 8'hC3}.
  - First sample_en → sample=8'hD2, valid pulses once.
  - Second sample_en → 8'hCA.
- Same pluck with KS_DECAY_EN, DECAY_SHIFT=4 → first sample 8'hC5.
- Length clamp and wrap:
  - len=0 → busy high for 2 clocks.
  - len=5 → busy high for 5 clocks. Over 12 sample_en strobes, ptr wraps 4→0 and no sample exceeds the previous buffer maximum.
- Priority:
  - pluck and sample_en on the same edge in PLAY → no valid, enters LOAD.
  - pluck and mute together → IDLE, sample=0.
  - mute mid-LOAD → busy drops on the next edge.
- Long run: len=100, 10000 sample_en strobes → output monotonically converges and valid count equals strobe count.
